// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared select codes, write-data source encodings and Tuse/Tnew helpers
// for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

  // 3-bit forwarding select codes (D and E stage muxes)
  localparam logic [2:0] SEL_NONE  = 3'b000;
  localparam logic [2:0] SEL_M_ALU = 3'b001;
  localparam logic [2:0] SEL_M_PC  = 3'b010;
  localparam logic [2:0] SEL_W_ALU = 3'b011;
  localparam logic [2:0] SEL_W_DM  = 3'b100;
  localparam logic [2:0] SEL_W_PC  = 3'b101;

  // 2-bit forwarding select codes (M stage DM write-data mux)
  localparam logic [1:0] SEL2_NONE  = 2'b00;
  localparam logic [1:0] SEL2_W_ALU = 2'b01;
  localparam logic [1:0] SEL2_W_DM  = 2'b10;
  localparam logic [1:0] SEL2_W_PC  = 2'b11;

  localparam logic [1:0] WD_NONE = 2'd0;
  localparam logic [1:0] WD_ALU  = 2'd1;
  localparam logic [1:0] WD_DM   = 2'd2;
  localparam logic [1:0] WD_PC   = 2'd3;

  localparam logic [1:0] TUSE_UNUSED = 2'd3;

  localparam logic [1:0] TNEW_E_ALU = 2'd1;
  localparam logic [1:0] TNEW_E_DM  = 2'd2;
  localparam logic [1:0] TNEW_E_PC  = 2'd1;
  localparam logic [1:0] TNEW_M_ALU = 2'd0;
  localparam logic [1:0] TNEW_M_DM  = 2'd1;
  localparam logic [1:0] TNEW_M_PC  = 2'd0;

  function automatic logic [1:0] tnew_e(input logic [1:0] wd);
    case (wd)
      WD_ALU:  tnew_e = TNEW_E_ALU;
      WD_DM:   tnew_e = TNEW_E_DM;
      WD_PC:   tnew_e = TNEW_E_PC;
      default: tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input logic [1:0] wd);
    case (wd)
      WD_ALU:  tnew_m = TNEW_M_ALU;
      WD_DM:   tnew_m = TNEW_M_DM;
      WD_PC:   tnew_m = TNEW_M_PC;
      default: tnew_m = 2'd0;
    endcase
  endfunction

  // A stage with Tnew 0 (including no-write) can never stall a reader.
  function automatic logic data_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] a3, input logic [1:0] tnew);
    data_hazard = (a3 != 5'd0) && (a3 == src) && (tuse != TUSE_UNUSED) && (tuse < tnew);
  endfunction

  function automatic logic [1:0] sel3_to_sel2(input logic [2:0] sel);
    case (sel)
      SEL_W_ALU: sel3_to_sel2 = SEL2_W_ALU;
      SEL_W_DM:  sel3_to_sel2 = SEL2_W_DM;
      SEL_W_PC:  sel3_to_sel2 = SEL2_W_PC;
      default:   sel3_to_sel2 = SEL2_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// Priority forwarding select: M-stage result wins over W-stage result;
// an M-stage load is not yet available so it falls through to W.
module fwd_sel_unit
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic [4:0] a3_m,
  input  logic [1:0] wd_m,
  input  logic [4:0] a3_w,
  input  logic [1:0] wd_w,
  output logic [2:0] sel
);

  logic match_m;
  logic match_w;

  assign match_m = (a3_m != 5'd0) && (a3_m == src_reg);
  assign match_w = (a3_w != 5'd0) && (a3_w == src_reg);

  always_comb begin
    sel = SEL_NONE;
    if (match_m && wd_m == WD_ALU) begin
      sel = SEL_M_ALU;
    end else if (match_m && wd_m == WD_PC) begin
      sel = SEL_M_PC;
    end else if (match_w) begin
      case (wd_w)
        WD_ALU:  sel = SEL_W_ALU;
        WD_DM:   sel = SEL_W_DM;
        WD_PC:   sel = SEL_W_PC;
        default: sel = SEL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline with a mult/div
// busy counter. Define HAZ_PERF_CNT_EN to add stall_cycles/md_stall_cycles.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  rs_tuse_D,
  input  logic [1:0]  rt_tuse_D,
  input  logic [4:0]  a3_D,
  input  logic [1:0]  wd_src_D,
  input  logic        md_start_D,
  input  logic        md_is_div_D,
  input  logic        md_use_D,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic [2:0]  sel_rs_D,
  output logic [2:0]  sel_rt_D,
  output logic [2:0]  sel_alua_E,
  output logic [2:0]  sel_alub_E,
  output logic [2:0]  sel_memdata_E,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles,
`endif
  output logic [1:0]  sel_dmwd_M
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  logic [4:0] a3_E, a3_M, a3_W;
  logic [1:0] wd_E, wd_M, wd_W;
  logic [4:0] rs_E, rt_E, rt_M;
  logic       md_start_E, md_div_E;
  logic [CNT_W-1:0] md_cnt;

  logic [1:0] tnew_E_cur, tnew_M_cur;
  logic       data_stall, md_stall;
  logic [2:0] sel_dm_w;

  assign tnew_E_cur = tnew_e(wd_E);
  assign tnew_M_cur = tnew_m(wd_M);

  // W stage has Tnew 0 by construction, so only E and M can stall.
  assign data_stall = data_hazard(rs_D, rs_tuse_D, a3_E, tnew_E_cur)
                    | data_hazard(rs_D, rs_tuse_D, a3_M, tnew_M_cur)
                    | data_hazard(rt_D, rt_tuse_D, a3_E, tnew_E_cur)
                    | data_hazard(rt_D, rt_tuse_D, a3_M, tnew_M_cur);

  assign md_busy  = (md_cnt != '0) | md_start_E;
  assign md_stall = (md_use_D | md_start_D) & md_busy;
  assign stall    = data_stall | md_stall;
  assign flush_E  = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_E       <= '0;
      wd_E       <= WD_NONE;
      rs_E       <= '0;
      rt_E       <= '0;
      md_start_E <= 1'b0;
      md_div_E   <= 1'b0;
      a3_M       <= '0;
      wd_M       <= WD_NONE;
      rt_M       <= '0;
      a3_W       <= '0;
      wd_W       <= WD_NONE;
    end else begin
      if (stall) begin
        a3_E       <= '0;
        wd_E       <= WD_NONE;
        rs_E       <= '0;
        rt_E       <= '0;
        md_start_E <= 1'b0;
        md_div_E   <= 1'b0;
      end else begin
        a3_E       <= a3_D;
        wd_E       <= wd_src_D;
        rs_E       <= rs_D;
        rt_E       <= rt_D;
        md_start_E <= md_start_D;
        md_div_E   <= md_is_div_D;
      end
      a3_M <= a3_E;
      wd_M <= wd_E;
      rt_M <= rt_E;
      a3_W <= a3_M;
      wd_W <= wd_M;
    end
  end

  // Countdown keeps running through stalls; bubbles carry md_start_E=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (md_start_E) begin
      md_cnt <= md_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall)    stall_cycles    <= stall_cycles + 32'd1;
      if (md_stall) md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

  fwd_sel_unit u_sel_rs_d (
    .src_reg (rs_D), .a3_m (a3_M), .wd_m (wd_M), .a3_w (a3_W), .wd_w (wd_W), .sel (sel_rs_D)
  );

  fwd_sel_unit u_sel_rt_d (
    .src_reg (rt_D), .a3_m (a3_M), .wd_m (wd_M), .a3_w (a3_W), .wd_w (wd_W), .sel (sel_rt_D)
  );

  fwd_sel_unit u_sel_rs_e (
    .src_reg (rs_E), .a3_m (a3_M), .wd_m (wd_M), .a3_w (a3_W), .wd_w (wd_W), .sel (sel_alua_E)
  );

  // ALU B and store data both read rt_E, so one select unit feeds both muxes.
  fwd_sel_unit u_sel_rt_e (
    .src_reg (rt_E), .a3_m (a3_M), .wd_m (wd_M), .a3_w (a3_W), .wd_w (wd_W), .sel (sel_alub_E)
  );
  assign sel_memdata_E = sel_alub_E;

  fwd_sel_unit u_sel_rt_m (
    .src_reg (rt_M), .a3_m (5'd0), .wd_m (WD_NONE), .a3_w (a3_W), .wd_w (wd_W), .sel (sel_dm_w)
  );
  assign sel_dmwd_M = sel3_to_sel2(sel_dm_w);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: instruction pairs from the pipeline
// with hand-computed stall and forwarding-select expectations.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] rs_tuse_D, rt_tuse_D, wd_src_D;
  logic       md_start_D, md_is_div_D, md_use_D;
  logic       stall, flush_E, md_busy;
  logic [2:0] sel_rs_D, sel_rt_D, sel_alua_E, sel_alub_E, sel_memdata_E;
  logic [1:0] sel_dmwd_M;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int n_busy;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .rs_D          (rs_D),
    .rt_D          (rt_D),
    .rs_tuse_D     (rs_tuse_D),
    .rt_tuse_D     (rt_tuse_D),
    .a3_D          (a3_D),
    .wd_src_D      (wd_src_D),
    .md_start_D    (md_start_D),
    .md_is_div_D   (md_is_div_D),
    .md_use_D      (md_use_D),
    .stall         (stall),
    .flush_E       (flush_E),
    .md_busy       (md_busy),
    .sel_rs_D      (sel_rs_D),
    .sel_rt_D      (sel_rt_D),
    .sel_alua_E    (sel_alua_E),
    .sel_alub_E    (sel_alub_E),
    .sel_memdata_E (sel_memdata_E),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles),
`endif
    .sel_dmwd_M    (sel_dmwd_M)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] rs_tu, input logic [1:0] rt_tu,
                       input logic [4:0] a3, input logic [1:0] wd,
                       input logic ms, input logic mdiv, input logic mu);
    rs_D = rs; rt_D = rt; rs_tuse_D = rs_tu; rt_tuse_D = rt_tu;
    a3_D = a3; wd_src_D = wd; md_start_D = ms; md_is_div_D = mdiv; md_use_D = mu;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  task automatic md_then_use(input logic is_div, input int exp_busy, input string tag);
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b0);
    #1;
    check({tag, "_start_no_stall"}, 32'(stall), 32'd0);
    tick();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);  // mflo $8
    #1;
    n_busy = 0;
    while (md_busy && n_busy < 40) begin
      check({tag, "_use_stall"}, 32'(stall), 32'd1);
      n_busy++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
    check({tag, "_release"}, 32'(stall), 32'd0);
    drain();
  endtask

  initial begin
    reset = 1'b0;
    nop();
    #2;
    check("rst_stall",   32'(stall),         32'd0);
    check("rst_busy",    32'(md_busy),       32'd0);
    check("rst_sel_rs",  32'(sel_rs_D),      32'd0);
    check("rst_sel_a",   32'(sel_alua_E),    32'd0);
    check("rst_sel_mem", 32'(sel_memdata_E), 32'd0);
    check("rst_sel_dm",  32'(sel_dmwd_M),    32'd0);
    reset = 1'b1;
    tick();

    // lw $1 ; addu $2,$1,$3
    drive(5'd4, 5'd1, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    #1;
    check("lw_use_stall", 32'(stall),   32'd1);
    check("lw_use_flush", 32'(flush_E), 32'd1);
    tick();
    check("lw_use_stall_done", 32'(stall), 32'd0);
    tick();
    nop();
    #1;
    check("lw_use_alua", 32'(sel_alua_E), 32'd4);
    check("lw_use_alub", 32'(sel_alub_E), 32'd0);
    drain();

    // addu $1 ; beq $1,$2
    drive(5'd5, 5'd6, 2'd1, 2'd1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("alu_br_stall", 32'(stall), 32'd1);
    tick();
    check("alu_br_stall_done", 32'(stall),    32'd0);
    check("alu_br_sel_rs",     32'(sel_rs_D), 32'd1);
    check("alu_br_sel_rt",     32'(sel_rt_D), 32'd0);
    drain();

    // jal ; jr $31
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("jal_jr_stall", 32'(stall), 32'd1);
    tick();
    check("jal_jr_stall_done", 32'(stall),    32'd0);
    check("jal_jr_sel_rs",     32'(sel_rs_D), 32'd2);
    drain();

    // lw $5 ; sw $5,0($6)
    drive(5'd7, 5'd5, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd6, 5'd5, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("lw_sw_no_stall", 32'(stall), 32'd0);
    tick();
    nop();
    #1;
    check("lw_sw_memdata_E", 32'(sel_memdata_E), 32'd0);
    tick();
    check("lw_sw_dmwd_M", 32'(sel_dmwd_M), 32'd2);
    drain();

    // addu $9 ; nop ; nop ; beq $9 -> W-stage ALU forward, no stall
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    drive(5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("w_alu_stall",  32'(stall),    32'd0);
    check("w_alu_sel_rs", 32'(sel_rs_D), 32'd3);
    check("w_alu_sel_rt", 32'(sel_rt_D), 32'd3);
    drain();

    // lw $0 ; reader of $0 with Tuse 0
    drive(5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("zero_stall",  32'(stall),    32'd0);
    tick();
    nop();
    #1;
    check("zero_sel_rs", 32'(sel_rs_D),   32'd0);
    check("zero_sel_a",  32'(sel_alua_E), 32'd0);
    drain();

    md_then_use(1'b1, 11, "div");
    md_then_use(1'b0, 6,  "mult");

    // reset asserted part way through a divide
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    tick();
    check("mid_div_busy", 32'(md_busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_busy", 32'(md_busy), 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_busy", 32'(md_busy), 32'd0);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    #1;
    check("post_rst_mflo_stall", 32'(stall), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
